// File: rtl/pe_link_rx_south_if.sv
// Local dequeue port of the south link receiver.
//   dout       : payload at the FIFO head (zero while dout_valid is low)
//   dout_last  : last flag at the FIFO head (zero while dout_valid is low)
//   dout_valid : FIFO non-empty
//   dout_ready : consumer accepts the head this cycle
// master = receiver side (drives the head), slave = local consumer.
interface pe_link_rx_south_if #(
    parameter int unsigned SOUTH_WIDTH = 130
);
    logic [SOUTH_WIDTH-3:0] dout;
    logic                   dout_last;
    logic                   dout_valid;
    logic                   dout_ready;

    modport master (
        output dout,
        output dout_last,
        output dout_valid,
        input  dout_ready
    );

    modport slave (
        input  dout,
        input  dout_last,
        input  dout_valid,
        output dout_ready
    );
endinterface

// File: rtl/pe_link_rx_south.sv
// Receive endpoint of the south inter-PE link. Captures valid link words into a
// FIFO while running, presents them to local logic on a valid/ready port and
// returns one upstream credit per consumed word.
//   clk, reset    : clock; asynchronous active-high reset
//   ap_start      : enables capture (FSM IDLE -> RUN)
//   in_from_south : link word {valid, last, payload}
//   out_to_south  : credit return, bit 0 = credit pulse, other bits zero
//   deq           : head-of-FIFO valid/ready port (dout, dout_last, dout_valid, dout_ready)
//   level         : FIFO occupancy
//   overflow      : sticky, a word arrived while the FIFO was full and not popping
//   pkt_count     : wrapping count of popped words with last = 1
module pe_link_rx_south #(
    parameter int unsigned SOUTH_WIDTH = 130,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ap_start,
    input  logic [SOUTH_WIDTH-1:0]        in_from_south,
    output logic [SOUTH_WIDTH-1:0]        out_to_south,
    pe_link_rx_south_if.master            deq,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output logic [15:0]                   pkt_count
);
    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
    localparam int unsigned LevelW = PtrW + 1;
    localparam int unsigned EntryW = SOUTH_WIDTH - 1;  // {last, payload}

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e              state_q, state_d;
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LevelW-1:0]   level_q, level_d;
    logic                overflow_q, overflow_d;
    logic [15:0]         pkt_count_q, pkt_count_d;
    logic                credit_q;
    logic [EntryW-1:0]   mem_q [FIFO_DEPTH];

    logic                empty;
    logic                full;
    logic                push_req;
    logic                push;
    logic                pop;
    logic [EntryW-1:0]   head;

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (ap_start)  state_d = StRun;
            StRun:  if (!ap_start) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        empty    = (level_q == '0);
        full     = (level_q == LevelW'(FIFO_DEPTH));
        head     = mem_q[rd_ptr_q];
        push_req = (state_q == StRun) && ap_start && in_from_south[SOUTH_WIDTH-1];
        pop      = !empty && deq.dout_ready;
        // A full FIFO still accepts a word when the head leaves in the same cycle.
        push     = push_req && (!full || pop);

        wr_ptr_d    = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        overflow_d  = overflow_q || (push_req && full && !pop);
        pkt_count_d = (pop && head[EntryW-1]) ? pkt_count_q + 16'd1 : pkt_count_q;

        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LevelW'(1);
            2'b01:   level_d = level_q - LevelW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            pkt_count_q <= '0;
            credit_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            pkt_count_q <= pkt_count_d;
            credit_q    <= pop;
        end
    end

    // Storage needs no reset; occupancy is tracked by level_q and the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_from_south[SOUTH_WIDTH-2:0];
        end
    end

    always_comb begin
        deq.dout_valid = !empty;
        deq.dout       = empty ? '0 : head[EntryW-2:0];
        deq.dout_last  = empty ? 1'b0 : head[EntryW-1];
        out_to_south   = {{(SOUTH_WIDTH-1){1'b0}}, credit_q};
        level          = level_q;
        overflow       = overflow_q;
        pkt_count      = pkt_count_q;
    end
endmodule
